// File: rtl/des_pkg.sv
// Shared DES constants: key-schedule permutations, the shift schedule, weak keys,
// and the round-function E/P/S tables. Vectors are stored MSB-first (DES bit 1 = MSB).
package des_pkg;

    localparam int          DES_ROUNDS = 16;
    localparam logic [3:0]  LAST_ROUND = 4'(DES_ROUNDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ks_state_e;

    localparam logic [6:0] PC1 [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [63:0] PARITY_MASK = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] WEAK_KEYS [4] = '{
        64'h0101_0101_0101_0101, 64'hFEFE_FEFE_FEFE_FEFE,
        64'hE0E0_E0E0_F1F1_F1F1, 64'h1F1F_1F1F_0E0E_0E0E
    };

    localparam logic [5:0] E_TAB [48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    localparam logic [5:0] P_TAB [32] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17, 6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,  6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    // Each S-box is 4 rows x 16 nibbles, row 0 column 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
        logic [5:0]   idx;
        logic [255:0] t;
        idx = {b[5], b[0], b[4:1]};
        t   = SBOX[box] << {idx, 2'b00};
        return t[255:252];
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = key[6'(64 - int'(PC1[6'(i)]))];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        if (n == 2'd2) r = {x[25:0], x[27:26]};
        else           r = {x[26:0], x[27]};
        return r;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        if (n == 2'd2) r = {x[1:0], x[27:2]};
        else           r = {x[0], x[27:1]};
        return r;
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

    function automatic logic is_weak(input logic [63:0] key);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hit = hit | ((key & PARITY_MASK) == (WEAK_KEYS[2'(i)] & PARITY_MASK));
        end
        return hit;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: 56-bit C||D (bit 1 = MSB) to a 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] subkey_o
);

    // Pure wiring permutation.
    always_comb begin
        subkey_o = '0;
        for (int i = 0; i < 48; i++) begin
            subkey_o[6'(47 - i)] = cd_i[6'(56 - int'(PC2[6'(i)]))];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator, encrypt or decrypt order, paced by adv.
// Optional weak-key flag built when DES_KEY_WEAK_DETECT_EN is defined.
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic        adv,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round,
    output logic        last_round,
    output logic        busy,
    output logic        weak_key
);

    ks_state_e   state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [55:0] pc1_s;
    logic [47:0] pc2_s;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic [3:0]  round_q, round_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        dec_q, dec_d;

    assign pc1_s = pc1_perm(key_in);

    // C/D tracks the halves of the subkey being presented; decrypt walks backwards by right-rotating.
    always_comb begin
        cd_d = cd_q;
        if (start) begin
            if (decrypt) cd_d = pc1_s;
            else         cd_d = rotl_cd(pc1_s, 2'd1);
        end else if ((state_q == ST_ACTIVE) && adv && valid_q && (round_q != LAST_ROUND)) begin
            if (dec_q) cd_d = rotr_cd(cd_q, SHIFT[LAST_ROUND - round_q]);
            else       cd_d = rotl_cd(cd_q, SHIFT[round_q + 4'd1]);
        end else begin
            cd_d = cd_q;
        end
    end

    des_pc2 u_pc2 (
        .cd_i     (cd_d),
        .subkey_o (pc2_s)
    );

    // Schedule FSM and output next-state; start wins over a simultaneous adv.
    always_comb begin
        state_d  = state_q;
        subkey_d = subkey_q;
        valid_d  = valid_q;
        round_d  = round_q;
        last_d   = last_q;
        busy_d   = busy_q;
        dec_d    = dec_q;
        if (start) begin
            state_d  = ST_ACTIVE;
            subkey_d = pc2_s;
            valid_d  = 1'b1;
            round_d  = 4'd0;
            last_d   = 1'b0;
            busy_d   = 1'b1;
            dec_d    = decrypt;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (adv && valid_q) begin
                        if (round_q == LAST_ROUND) begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            round_d = 4'd0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            if (HOLD_LAST) subkey_d = subkey_q;
                            else           subkey_d = '0;
                        end else begin
                            subkey_d = pc2_s;
                            round_d  = round_q + 4'd1;
                            last_d   = (round_q == (LAST_ROUND - 4'd1));
                        end
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cd_q     <= '0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            round_q  <= 4'd0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            round_q  <= round_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            dec_q    <= dec_d;
        end
    end

`ifdef DES_KEY_WEAK_DETECT_EN
    logic weak_q, weak_d;

    // Weak-key verdict is captured with the key and held until the next load.
    always_comb begin
        if (start) weak_d = is_weak(key_in);
        else       weak_d = weak_q;
    end

    // Weak-key flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) weak_q <= 1'b0;
        else        weak_q <= weak_d;
    end

    assign weak_key = weak_q;
`else
    assign weak_key = 1'b0;
`endif

    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign round        = round_q;
    assign last_round   = last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule using the classic 133457799BBCDFF1 subkey table.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n, start, decrypt, adv;
    logic [63:0] key_in;
    logic [47:0] subkey;
    logic        subkey_valid, last_round, busy, weak_key;
    logic [3:0]  round;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [47:0] sk;
        logic [3:0]  rnd;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    logic [47:0] known_k [16];
    logic [63:0] weak_keys [4];
    logic [47:0] weak_sk [4];

    localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;
`ifdef DES_KEY_WEAK_DETECT_EN
    localparam logic WEAK_EN = 1'b1;
`else
    localparam logic WEAK_EN = 1'b0;
`endif

    des_key_schedule #(.HOLD_LAST(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .adv          (adv),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round        (round),
        .last_round   (last_round),
        .busy         (busy),
        .weak_key     (weak_key)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every presented subkey; an entry retires when adv accepts it.
    always @(negedge clk) begin
        if (rst_n && subkey_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_valid", 64'(subkey_valid), 64'd0);
            end else begin
                mon_e = sb_q[0];
                check_val("subkey", 64'(subkey), 64'(mon_e.sk));
                check_val("round", 64'(round), 64'(mon_e.rnd));
                check_val("last_round", 64'(last_round), 64'(mon_e.rnd == 4'd15));
                check_val("busy", 64'(busy), 64'd1);
                if (adv) void'(sb_q.pop_front());
            end
        end
    end

    // Called at posedge+1; kind 0 = encrypt table, 1 = reversed table, else constant cval.
    task automatic start_sched(input logic [63:0] key, input logic dec, input int kind,
                               input logic [47:0] cval);
        exp_t e;
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        key_in  = ~key;
        decrypt = ~dec;
        sb_q.delete();
        for (int r = 0; r < 16; r++) begin
            e.rnd = 4'(r);
            case (kind)
                0:       e.sk = known_k[r];
                1:       e.sk = known_k[15 - r];
                default: e.sk = cval;
            endcase
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input logic rand_adv);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            #1;
            if (rand_adv) adv = 1'($urandom_range(0, 1));
        end
        check_val("drain_done", 64'(done), 64'd1);
    endtask

    task automatic end_checks(input logic [47:0] hold);
        @(negedge clk);
        check_val("end_valid", 64'(subkey_valid), 64'd0);
        check_val("end_busy", 64'(busy), 64'd0);
        check_val("end_last", 64'(last_round), 64'd0);
        check_val("end_round", 64'(round), 64'd0);
        check_val("end_subkey_hold", 64'(subkey), 64'(hold));
    endtask

    task automatic wait_round(input logic [3:0] r);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (subkey_valid && (round == r)) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("wait_round", 64'(seen), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_subkey"}, 64'(subkey), 64'd0);
        check_val({tag, "_valid"}, 64'(subkey_valid), 64'd0);
        check_val({tag, "_round"}, 64'(round), 64'd0);
        check_val({tag, "_last"}, 64'(last_round), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_weak"}, 64'(weak_key), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        known_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        weak_keys = '{64'h0101010101010101, 64'hFEFEFEFEFEFEFEFE,
                      64'hE0E0E0E0F1F1F1F1, 64'h1F1F1F1F0E0E0E0E};
        weak_sk   = '{48'h000000000000, 48'hFFFFFFFFFFFF, 48'hFFFFFF000000, 48'h000000FFFFFF};

        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; adv = 1'b0; key_in = '0;
        #7;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // Encrypt, adv held high.
        @(posedge clk); #1;
        adv = 1'b1;
        start_sched(KEY_A, 1'b0, 0, '0);
        drain(1'b0);
        end_checks(known_k[15]);

        // adv while idle is ignored.
        repeat (3) @(negedge clk);
        check_val("idle_adv_valid", 64'(subkey_valid), 64'd0);

        // Decrypt: reversed sequence.
        @(posedge clk); #1;
        start_sched(KEY_A, 1'b1, 1, '0);
        drain(1'b0);
        end_checks(known_k[0]);

        // Stalls: random adv.
        @(posedge clk); #1;
        adv = 1'b0;
        start_sched(KEY_A, 1'b0, 0, '0);
        drain(1'b1);
        end_checks(known_k[15]);

        // Restart at round 7 with simultaneous adv.
        @(posedge clk); #1;
        adv = 1'b1;
        start_sched(KEY_A, 1'b1, 1, '0);
        wait_round(4'd7);
        start_sched(KEY_A, 1'b0, 0, '0);
        drain(1'b0);
        end_checks(known_k[15]);

        // Asynchronous reset at round 5.
        @(posedge clk); #1;
        start_sched(KEY_A, 1'b0, 0, '0);
        wait_round(4'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb_q.delete();
        adv = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        adv = 1'b1;
        start_sched(KEY_A, 1'b0, 0, '0);
        drain(1'b0);
        end_checks(known_k[15]);

        // Weak keys: constant subkeys and the optional flag.
        for (int w = 0; w < 4; w++) begin
            @(posedge clk); #1;
            start_sched(weak_keys[w], 1'b0, 2, weak_sk[w]);
            @(negedge clk);
            check_val("weak_flag", 64'(weak_key), 64'(WEAK_EN));
            drain(1'b0);
            end_checks(weak_sk[w]);
        end
        @(posedge clk); #1;
        start_sched(KEY_A, 1'b0, 0, '0);
        @(negedge clk);
        check_val("weak_flag_normal", 64'(weak_key), 64'd0);
        drain(1'b0);
        end_checks(known_k[15]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
